fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage of the 5-stage pipeline, directly upstream of the IF/ID latch. It:
- owns the PC register and drives the instruction-memory request;
- presents each returned instruction with its next-PC (PC+4) to the IF/ID latch, qualified by a valid strobe;
- captures instructions that arrive during a pipeline stall in a one-entry hold buffer;
- applies branch/jump redirects;
- stops fetching after a HALT opcode.

Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded on reset.
- HALT_OP, 6'b111111, opcode field value that stops fetch.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- ihit  input  1  imem returned an instruction for imemaddr this cycle.
- imemload  input  32  instruction word; valid when ihit=1.
- stall  input  1  hazard unit holds IF/ID; fetch must not deliver.
- redirect_en  input  1  taken branch/jump resolved downstream.
- redirect_pc  input  32  target PC for redirect.
- imemREN  output  1  instruction read request.
- imemaddr  output  32  fetch address (= PC).
- fetch_valid  output  1  fetch_npc/fetch_imemload valid; drives IF/ID update enable.
- fetch_npc  output  32  address of delivered instruction + 4.
- fetch_imemload  output  32  delivered instruction.
- halted  output  1  fetch has stopped on HALT.

Behaviour:
- State: pc[31:0], hold_instr[31:0], hold_npc[31:0], FSM {RUN, HOLD, HALTED}.
- Reset (RST=1 at edge):
  - pc=PC_INIT, state=RUN, hold regs=0.
  - Outputs in the cycle after reset: imemREN=1, imemaddr=PC_INIT, fetch_valid=0, fetch_npc=0, fetch_imemload=0, halted=0.
  - RST has priority over every other input, including mid-HOLD and HALTED.
- imemaddr=pc always.
- imemREN=1 only in RUN.
- halted=1 only in HALTED.
- Outputs are combinational from state and inputs. fetch_npc/fetch_imemload read 0 whenever fetch_valid=0.
- Redirect:
  - Highest priority after reset, in every state.
  - fetch_valid=0 that cycle; any same-cycle ihit is discarded; hold buffer is cleared.
  - Next cycle: pc={redirect_pc[31:2],2'b00}, state=RUN.
  - IF/ID flush is driven separately by the hazard unit.
- RUN, no redirect:
  - ihit=1, stall=0: fetch_valid=1, fetch_npc=pc+4, fetch_imemload=imemload; pc<=pc+4.
  - ihit=1, stall=1: fetch_valid=0; hold_instr<=imemload, hold_npc<=pc+4; pc<=pc+4; state<=HOLD.
  - ihit=0: fetch_valid=0; pc holds. No request timeout; waits indefinitely.
  - Delivered word with imemload[31:26]==HALT_OP (direct or from HOLD): instruction is delivered normally, pc is not advanced, state<=HALTED.
  - Captured HALT word: pc is not advanced and HOLD is entered; the HALT check happens on delivery from HOLD.
- HOLD, no redirect:
  - imemREN=0; ihit is ignored.
  - stall=1: fetch_valid=0, remain in HOLD.
  - stall=0: fetch_valid=1, outputs hold_npc/hold_instr; state<=RUN (or HALTED if the held word is HALT).
- HALTED:
  - imemREN=0, fetch_valid=0; ihit and stall ignored.
  - Exits only via redirect (wrong-path HALT) or RST.
- Arithmetic:
  - pc+4 is 32-bit modulo: 32'hFFFF_FFFC+4 = 0.
  - redirect_pc[1:0] is ignored.
- At most one instruction is delivered per cycle; none is ever duplicated or dropped except by redirect.

Optional Feature:
FETCH_PERF_EN defined:
- Adds output ports fetch_count[31:0] (+1 per cycle with fetch_valid=1) and stall_count[31:0] (+1 per cycle in HOLD with stall=1).
- Both reset to 0 on RST and wrap modulo 2^32.

FETCH_PERF_EN undefined:
- Ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then ihit=1 each cycle with imemload=32'h2008_0001, 32'h2009_0002 -> imemaddr 0,4,8; fetch_valid=1 each cycle; fetch_npc=4 then 8.
- At pc=8, ihit=1, imemload=32'hAAAA_0000, stall=1 for 3 cycles -> fetch_valid=0 for 3 cycles, imemREN=0, imemaddr=12. Stall drops -> fetch_valid=1, fetch_npc=12, fetch_imemload=32'hAAAA_0000; next cycle imemREN=1, imemaddr=12.
- redirect_en=1, redirect_pc=32'h0000_0103 with ihit=1 in the same cycle -> fetch_valid=0 that cycle; next imemaddr=32'h0000_0100. Repeat while in HOLD -> held word never delivered.
- Deliver 32'hFC00_0000 at pc=0x20 -> fetch_valid=1, fetch_npc=0x24. Then halted=1, imemREN=0, imemaddr stays 0x20 despite ihit pulses. redirect_pc=0x40 -> RUN, imemaddr=0x40.
- RST=1 asserted while in HOLD with stall=1 -> next cycle pc=PC_INIT, RUN, hold discarded, fetch_valid=0.
- Redirect to 32'hFFFF_FFFC, ihit=1, no stall -> fetch_npc=0, next imemaddr=0. With FETCH_PERF_EN: fetch_count and stall_count match the number of delivered and stalled-hold cycles.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, imem request, one-entry stall hold buffer,
// redirect and HALT handling. Optional perf counters under `FETCH_PERF_EN`.
module fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP = 6'b111111
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic        fetch_valid,
  output logic [31:0] fetch_npc,
  output logic [31:0] fetch_imemload,
`ifdef FETCH_PERF_EN
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count,
`endif
  output logic        halted
);

  typedef enum logic [1:0] {RUN, HOLD, HALTED} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] hold_instr, hold_instr_n;
  logic [31:0] hold_npc, hold_npc_n;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc + 32'd4;
  assign imemaddr = pc;
  assign imemREN  = (state == RUN);
  assign halted   = (state == HALTED);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= RUN;
      pc         <= PC_INIT;
      hold_instr <= '0;
      hold_npc   <= '0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      hold_instr <= hold_instr_n;
      hold_npc   <= hold_npc_n;
    end
  end

  always_comb begin
    state_n        = state;
    pc_n           = pc;
    hold_instr_n   = hold_instr;
    hold_npc_n     = hold_npc;
    fetch_valid    = 1'b0;
    fetch_npc      = '0;
    fetch_imemload = '0;

    if (redirect_en) begin
      state_n      = RUN;
      pc_n         = {redirect_pc[31:2], 2'b00};
      hold_instr_n = '0;
      hold_npc_n   = '0;
    end else begin
      unique case (state)
        RUN: begin
          if (ihit) begin
            // A HALT word never advances pc, whether delivered now or captured
            if (!stall) begin
              fetch_valid    = 1'b1;
              fetch_npc      = pc_plus4;
              fetch_imemload = imemload;
              if (imemload[31:26] == HALT_OP) state_n = HALTED;
              else                            pc_n    = pc_plus4;
            end else begin
              hold_instr_n = imemload;
              hold_npc_n   = pc_plus4;
              state_n      = HOLD;
              if (imemload[31:26] != HALT_OP) pc_n = pc_plus4;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            fetch_valid    = 1'b1;
            fetch_npc      = hold_npc;
            fetch_imemload = hold_instr;
            state_n        = (hold_instr[31:26] == HALT_OP) ? HALTED : RUN;
          end
        end
        HALTED: ;
        default: state_n = RUN;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (fetch_valid)             fetch_count <= fetch_count + 32'd1;
      if (state == HOLD && stall)  stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed test-plan sequence, then random
// traffic checked every cycle against a behavioural model.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST, ihit, stall, redirect_en;
  logic [31:0] imemload, redirect_pc;
  logic        imemREN, fetch_valid, halted;
  logic [31:0] imemaddr, fetch_npc, fetch_imemload;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count, stall_count;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model: fetch pointer, pending held word, halted flag
  logic [31:0] m_pc, m_hword, m_hnpc;
  logic        m_held, m_halted;
  logic [31:0] m_fcnt, m_scnt;

  always #5 CLK = ~CLK;

  fetch_unit #(.PC_INIT(32'h0000_0000), .HALT_OP(6'b111111)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload), .stall(stall),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .imemREN(imemREN), .imemaddr(imemaddr), .fetch_valid(fetch_valid),
    .fetch_npc(fetch_npc), .fetch_imemload(fetch_imemload),
`ifdef FETCH_PERF_EN
    .fetch_count(fetch_count), .stall_count(stall_count),
`endif
    .halted(halted)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_halt(input logic [31:0] w);
    return w[31:26] == 6'b111111;
  endfunction

  // One clock: drive inputs, check combinational outputs, then advance the model.
  task automatic cycle(input bit rst, input bit hit, input logic [31:0] load,
                       input bit stl, input bit re, input logic [31:0] rpc);
    bit          dv;
    logic [31:0] dnpc, dword;
    @(negedge CLK);
    RST = rst; ihit = hit; imemload = load; stall = stl;
    redirect_en = re; redirect_pc = rpc;
    #1;
    dv = 0; dnpc = 0; dword = 0;
    if (!re && !m_halted) begin
      if (m_held) begin
        if (!stl) begin dv = 1; dnpc = m_hnpc; dword = m_hword; end
      end else if (hit && !stl) begin
        dv = 1; dnpc = m_pc + 32'd4; dword = load;
      end
    end
    check("imemREN",   {31'd0, imemREN},     {31'd0, !m_held && !m_halted});
    check("imemaddr",  imemaddr,             m_pc);
    check("halted",    {31'd0, halted},      {31'd0, m_halted});
    check("valid",     {31'd0, fetch_valid}, {31'd0, dv});
    check("npc",       fetch_npc,            dnpc);
    check("instr",     fetch_imemload,       dword);
`ifdef FETCH_PERF_EN
    check("fetch_cnt", fetch_count, m_fcnt);
    check("stall_cnt", stall_count, m_scnt);
`endif
    @(posedge CLK);
    if (rst) begin
      m_pc = 32'h0; m_held = 0; m_halted = 0; m_hword = 0; m_hnpc = 0;
      m_fcnt = 0; m_scnt = 0;
    end else begin
      if (dv) m_fcnt++;
      if (m_held && stl) m_scnt++;
      if (re) begin
        m_pc = rpc & ~32'd3; m_held = 0; m_halted = 0; m_hword = 0; m_hnpc = 0;
      end else if (m_halted) begin
      end else if (m_held) begin
        if (!stl) begin m_held = 0; m_halted = is_halt(m_hword); end
      end else if (hit) begin
        if (stl) begin
          m_held = 1; m_hword = load; m_hnpc = m_pc + 32'd4;
        end else if (is_halt(load)) begin
          m_halted = 1;
        end
        if (!is_halt(load)) m_pc = m_pc + 32'd4;
      end
    end
  endtask

  initial begin
    logic [31:0] w;
    m_pc = 0; m_held = 0; m_halted = 0; m_hword = 0; m_hnpc = 0;
    m_fcnt = 0; m_scnt = 0;
    RST = 1; ihit = 0; imemload = 0; stall = 0; redirect_en = 0; redirect_pc = 0;

    // Reset and straight-line fetch
    @(posedge CLK);
    cycle(1, 0, 32'h0, 0, 0, 32'h0);
    cycle(0, 1, 32'h2008_0001, 0, 0, 32'h0);
    cycle(0, 1, 32'h2009_0002, 0, 0, 32'h0);
    // Stall capture for 3 cycles, then delivery from the hold buffer
    cycle(0, 1, 32'hAAAA_0000, 1, 0, 32'h0);
    cycle(0, 1, 32'hBBBB_0000, 1, 0, 32'h0);
    cycle(0, 1, 32'hCCCC_0000, 1, 0, 32'h0);
    cycle(0, 1, 32'hDDDD_0000, 0, 0, 32'h0);
    check("hold_npc_12", fetch_npc, 32'd12);
    cycle(0, 0, 32'h0, 0, 0, 32'h0);
    check("resume_addr", imemaddr, 32'd12);
    // Redirect with same-cycle ihit, then redirect while holding
    cycle(0, 1, 32'h1234_5678, 0, 1, 32'h0000_0103);
    cycle(0, 1, 32'h5555_0000, 1, 0, 32'h0);
    cycle(0, 0, 32'h0, 1, 1, 32'h0000_0103);
    cycle(0, 0, 32'h0, 0, 0, 32'h0);
    check("redir_addr", imemaddr, 32'h100);
    // HALT delivery, ignored ihit pulses, exit via redirect
    cycle(0, 0, 32'h0, 0, 1, 32'h20);
    cycle(0, 1, 32'hFC00_0000, 0, 0, 32'h0);
    cycle(0, 1, 32'h0000_0001, 0, 0, 32'h0);
    cycle(0, 1, 32'h0000_0002, 1, 0, 32'h0);
    check("halt_addr", imemaddr, 32'h20);
    cycle(0, 0, 32'h0, 0, 1, 32'h40);
    cycle(0, 0, 32'h0, 0, 0, 32'h0);
    // Captured HALT in hold, delivered later
    cycle(0, 1, 32'hFC00_1111, 1, 0, 32'h0);
    cycle(0, 0, 32'h0, 0, 0, 32'h0);
    cycle(0, 1, 32'h0, 0, 0, 32'h0);
    // Reset while holding under stall
    cycle(0, 0, 32'h0, 0, 1, 32'h80);
    cycle(0, 1, 32'h7777_0000, 1, 0, 32'h0);
    cycle(1, 0, 32'h0, 1, 0, 32'h0);
    cycle(0, 0, 32'h0, 1, 0, 32'h0);
    // PC wrap
    cycle(0, 0, 32'h0, 0, 1, 32'hFFFF_FFFC);
    cycle(0, 1, 32'h1111_0000, 0, 0, 32'h0);
    cycle(0, 0, 32'h0, 0, 0, 32'h0);
    check("wrap_addr", imemaddr, 32'h0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      w = $urandom;
      if ($urandom_range(0, 9) == 0) w[31:26] = 6'b111111;
      cycle($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, w,
            $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
